peak_pair_hasher: RTL and testbench

- Sits directly downstream of the spectral peak picker.
- Takes one frame of peaks per valid_in pulse: amplitude, frequency-bin index and frame time counter.
- Pairs each new frame's peaks (targets) with peaks from the previous HIST_DEPTH accepted frames (anchors), forming constellation hashes (anchor freq, target freq, dt, anchor time).
- Streams the hashes out one per valid/ready handshake to the fingerprint store / bus interface.

---
 rtl/peak_pair_hasher.sv | 194 +++++++++++++++++++
 tb/tb_peak_pair_hasher.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/peak_pair_hasher.sv
// Pairs each newly accepted frame of spectral peaks with the peaks of the last
// HIST_DEPTH frames and streams constellation hashes over a valid/ready port.
module peak_pair_hasher #(
    parameter int unsigned PEAKS      = 4,
    parameter int unsigned FREQ_WIDTH = 9,
    parameter int unsigned AMPL_WIDTH = 16,
    parameter int unsigned TIME_WIDTH = 16,
    parameter int unsigned HIST_DEPTH = 3,
    parameter int unsigned DT_WIDTH   = 6
) (
    input  logic                                 CLOCK_50,
    input  logic                                 reset,
    input  logic                                 valid_in,
    input  logic [PEAKS-1:0][AMPL_WIDTH-1:0]     ampl_in,
    input  logic [PEAKS-1:0][FREQ_WIDTH-1:0]     freq_in,
    input  logic [TIME_WIDTH-1:0]                time_in,
    input  logic                                 hash_ready,
    output logic                                 hash_valid,
    output logic [FREQ_WIDTH-1:0]                hash_f_anchor,
    output logic [FREQ_WIDTH-1:0]                hash_f_target,
    output logic [DT_WIDTH-1:0]                  hash_dt,
    output logic [TIME_WIDTH-1:0]                hash_t_anchor,
    output logic                                 busy,
    output logic [7:0]                           frames_dropped
);

    localparam int unsigned PW = (PEAKS > 1) ? $clog2(PEAKS) : 1;
    localparam int unsigned HW = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
    localparam logic [PW-1:0]         P_LAST = PW'(PEAKS - 1);
    localparam logic [HW-1:0]         H_LAST = HW'(HIST_DEPTH - 1);
    localparam logic [TIME_WIDTH-1:0] DT_MAX = TIME_WIDTH'((1 << DT_WIDTH) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAIR,
        S_WAIT,
        S_COMMIT
    } state_e;

    state_e                          state_q;
    logic [HW-1:0]                   h_q;
    logic [PW-1:0]                   a_q;
    logic [PW-1:0]                   t_q;

    // Only "slot holds a peak" matters for pairing, so amplitudes collapse to one bit.
    logic [PEAKS-1:0]                cur_pres_q;
    logic [PEAKS-1:0][FREQ_WIDTH-1:0] cur_freq_q;
    logic [TIME_WIDTH-1:0]           cur_time_q;

    logic [HIST_DEPTH-1:0]           hist_valid_q;
    logic [PEAKS-1:0]                hist_pres_q [HIST_DEPTH];
    logic [PEAKS-1:0][FREQ_WIDTH-1:0] hist_freq_q [HIST_DEPTH];
    logic [TIME_WIDTH-1:0]           hist_time_q [HIST_DEPTH];

    logic                            hash_valid_q;
    logic [FREQ_WIDTH-1:0]           hash_f_anchor_q;
    logic [FREQ_WIDTH-1:0]           hash_f_target_q;
    logic [DT_WIDTH-1:0]             hash_dt_q;
    logic [TIME_WIDTH-1:0]           hash_t_anchor_q;
    logic                            busy_q;
    logic [7:0]                      dropped_q;

    logic [PEAKS-1:0]                pres_in_c;
    logic [TIME_WIDTH-1:0]           dt_c;
    logic                            pair_ok_c;
    logic                            last_c;
    logic [HW-1:0]                   h_d;
    logic [PW-1:0]                   a_d;
    logic [PW-1:0]                   t_d;

    // Pair qualification for the current (h, a, t) and the next index in t-innermost order.
    always_comb begin
        for (int unsigned i = 0; i < PEAKS; i++) begin
            pres_in_c[i] = !ampl_in[i][AMPL_WIDTH-1] && (ampl_in[i] != '0);
        end
        dt_c      = cur_time_q - hist_time_q[h_q];
        pair_ok_c = hist_valid_q[h_q] && hist_pres_q[h_q][a_q] && cur_pres_q[t_q]
                    && (dt_c != '0) && (dt_c <= DT_MAX);
        last_c    = (h_q == H_LAST) && (a_q == P_LAST) && (t_q == P_LAST);
        h_d = h_q;
        a_d = a_q;
        t_d = t_q;
        if (last_c) begin
            h_d = '0;
            a_d = '0;
            t_d = '0;
        end else if (t_q != P_LAST) begin
            t_d = t_q + 1'b1;
        end else begin
            t_d = '0;
            if (a_q != P_LAST) begin
                a_d = a_q + 1'b1;
            end else begin
                a_d = '0;
                h_d = h_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            h_q             <= '0;
            a_q             <= '0;
            t_q             <= '0;
            cur_pres_q      <= '0;
            cur_freq_q      <= '0;
            cur_time_q      <= '0;
            hist_valid_q    <= '0;
            for (int unsigned k = 0; k < HIST_DEPTH; k++) begin
                hist_pres_q[k] <= '0;
                hist_freq_q[k] <= '0;
                hist_time_q[k] <= '0;
            end
            hash_valid_q    <= 1'b0;
            hash_f_anchor_q <= '0;
            hash_f_target_q <= '0;
            hash_dt_q       <= '0;
            hash_t_anchor_q <= '0;
            busy_q          <= 1'b0;
            dropped_q       <= '0;
        end else begin
            if (valid_in && (state_q != S_IDLE) && (dropped_q != 8'hFF)) begin
                dropped_q <= dropped_q + 8'd1;
            end
            case (state_q)
                S_IDLE: begin
                    if (valid_in) begin
                        cur_pres_q <= pres_in_c;
                        cur_freq_q <= freq_in;
                        cur_time_q <= time_in;
                        h_q        <= '0;
                        a_q        <= '0;
                        t_q        <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= S_PAIR;
                    end
                end
                S_PAIR: begin
                    if (pair_ok_c) begin
                        hash_f_anchor_q <= hist_freq_q[h_q][a_q];
                        hash_f_target_q <= cur_freq_q[t_q];
                        hash_dt_q       <= DT_WIDTH'(dt_c);
                        hash_t_anchor_q <= hist_time_q[h_q];
                        hash_valid_q    <= 1'b1;
                        state_q         <= S_WAIT;
                    end else begin
                        h_q     <= h_d;
                        a_q     <= a_d;
                        t_q     <= t_d;
                        state_q <= last_c ? S_COMMIT : S_PAIR;
                    end
                end
                S_WAIT: begin
                    if (hash_ready) begin
                        hash_valid_q <= 1'b0;
                        h_q          <= h_d;
                        a_q          <= a_d;
                        t_q          <= t_d;
                        state_q      <= last_c ? S_COMMIT : S_PAIR;
                    end
                end
                S_COMMIT: begin
                    // Age the history by one frame; the oldest entry falls off the end.
                    for (int unsigned k = 1; k < HIST_DEPTH; k++) begin
                        hist_pres_q[k]  <= hist_pres_q[k-1];
                        hist_freq_q[k]  <= hist_freq_q[k-1];
                        hist_time_q[k]  <= hist_time_q[k-1];
                        hist_valid_q[k] <= hist_valid_q[k-1];
                    end
                    hist_pres_q[0]  <= cur_pres_q;
                    hist_freq_q[0]  <= cur_freq_q;
                    hist_time_q[0]  <= cur_time_q;
                    hist_valid_q[0] <= 1'b1;
                    busy_q          <= 1'b0;
                    state_q         <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign hash_valid     = hash_valid_q;
    assign hash_f_anchor  = hash_f_anchor_q;
    assign hash_f_target  = hash_f_target_q;
    assign hash_dt        = hash_dt_q;
    assign hash_t_anchor  = hash_t_anchor_q;
    assign busy           = busy_q;
    assign frames_dropped = dropped_q;

endmodule

// File: tb/tb_peak_pair_hasher.sv
// Scoreboard bench for peak_pair_hasher: a frame-level reference model queues
// expected hashes, and an independent monitor checks every handshake.
module tb_peak_pair_hasher;

    localparam int unsigned PEAKS = 4;
    localparam int unsigned FW    = 9;
    localparam int unsigned AW    = 16;
    localparam int unsigned TW    = 16;
    localparam int unsigned HD    = 3;
    localparam int unsigned DW    = 6;

    typedef struct packed {
        logic [TW-1:0]              t;
        logic [PEAKS-1:0][AW-1:0]   ampl;
        logic [PEAKS-1:0][FW-1:0]   freq;
    } frame_t;

    typedef struct packed {
        logic [FW-1:0] fa;
        logic [FW-1:0] ft;
        logic [DW-1:0] dt;
        logic [TW-1:0] ta;
    } hash_t;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     valid_in;
    logic [PEAKS-1:0][AW-1:0] ampl_in;
    logic [PEAKS-1:0][FW-1:0] freq_in;
    logic [TW-1:0]            time_in;
    logic                     hash_ready;
    logic                     hash_valid;
    logic [FW-1:0]            hash_f_anchor;
    logic [FW-1:0]            hash_f_target;
    logic [DW-1:0]            hash_dt;
    logic [TW-1:0]            hash_t_anchor;
    logic                     busy;
    logic [7:0]               frames_dropped;

    peak_pair_hasher #(
        .PEAKS(PEAKS), .FREQ_WIDTH(FW), .AMPL_WIDTH(AW),
        .TIME_WIDTH(TW), .HIST_DEPTH(HD), .DT_WIDTH(DW)
    ) dut (
        .CLOCK_50      (clk),
        .reset         (rst),
        .valid_in      (valid_in),
        .ampl_in       (ampl_in),
        .freq_in       (freq_in),
        .time_in       (time_in),
        .hash_ready    (hash_ready),
        .hash_valid    (hash_valid),
        .hash_f_anchor (hash_f_anchor),
        .hash_f_target (hash_f_target),
        .hash_dt       (hash_dt),
        .hash_t_anchor (hash_t_anchor),
        .busy          (busy),
        .frames_dropped(frames_dropped)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_pass   = 0;
    hash_t  exp_q[$];
    frame_t mdl_hist[$];
    int     exp_drops = 0;
    int     rdy_mode  = 0;  // 0 high, 1 random, 2 backpressure at first hash, 3 low
    int     bp_left   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference: every present history peak pairs with every present new peak
    // whose modular time distance is 1..2^DW-1, newest history frame first.
    task automatic model_frame(input frame_t f, output int n);
        int    d;
        hash_t e;
        n = 0;
        for (int h = 0; h < mdl_hist.size(); h++)
            for (int a = 0; a < PEAKS; a++)
                for (int t = 0; t < PEAKS; t++)
                    if (int'($signed(mdl_hist[h].ampl[a])) > 0 && int'($signed(f.ampl[t])) > 0) begin
                        d = (int'(f.t) - int'(mdl_hist[h].t)) & 32'hFFFF;
                        if (d >= 1 && d <= (1 << DW) - 1) begin
                            e.fa = mdl_hist[h].freq[a];
                            e.ft = f.freq[t];
                            e.dt = DW'(d);
                            e.ta = mdl_hist[h].t;
                            exp_q.push_back(e);
                            n++;
                        end
                    end
        mdl_hist.push_front(f);
        if (mdl_hist.size() > HD) void'(mdl_hist.pop_back());
    endtask

    function automatic frame_t mk(input int t, input int f0, input int a0, input int f1, input int a1);
        frame_t f;
        f         = '0;
        f.t       = TW'(t);
        f.freq[0] = FW'(f0);
        f.ampl[0] = AW'(a0);
        f.freq[1] = FW'(f1);
        f.ampl[1] = AW'(a1);
        return f;
    endfunction

    task automatic send_frame(input frame_t f, input int mode, input int drop_at);
        int n;
        int cnt;
        bit done;
        @(posedge clk); #1;
        rdy_mode = mode;
        bp_left  = 6;
        valid_in = 1'b1;
        ampl_in  = f.ampl;
        freq_in  = f.freq;
        time_in  = f.t;
        model_frame(f, n);
        @(posedge clk); #1;
        valid_in = 1'b0;
        ampl_in  = {$urandom, $urandom};
        freq_in  = {2{$urandom}};
        time_in  = TW'($urandom);
        cnt  = 0;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            valid_in = 1'b0;
            if (busy) begin
                cnt++;
                if (cnt == drop_at) begin
                    valid_in = 1'b1;
                    if (exp_drops < 255) exp_drops++;
                end
            end else begin
                done = 1'b1;
            end
        end
        valid_in = 1'b0;
        chk("busy_done", 64'(done), 64'(1));
        if (mode == 0) chk("busy_len", 64'(cnt), 64'(49 + n));
        chk("frames_dropped", 64'(frames_dropped), 64'(exp_drops));
        chk("drain", 64'(exp_q.size()), 64'(0));
    endtask

    // Ready driver, updated just after each rising edge.
    initial begin
        hash_ready = 1'b0;
        forever begin
            @(posedge clk); #2;
            case (rdy_mode)
                0: hash_ready = 1'b1;
                1: hash_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (hash_valid && bp_left > 0) bp_left--;
                    hash_ready = (bp_left == 0);
                end
                default: hash_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops one expected hash per handshake and checks hold stability.
    initial begin
        hash_t got;
        hash_t held;
        bit    hold;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            got = {hash_f_anchor, hash_f_target, hash_dt, hash_t_anchor};
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (hold) chk("hold_stable", 64'({hash_valid, got}), 64'({1'b1, held}));
                if (hash_valid && hash_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_hash: got %0h, expected no hash", got);
                    end else begin
                        chk("hash", 64'(got), 64'(exp_q.pop_front()));
                    end
                end
                hold = hash_valid && !hash_ready;
                held = got;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        frame_t f;
        bit     got_v;
        int     t_now;
        rst      = 1'b0;
        valid_in = 1'b0;
        ampl_in  = '0;
        freq_in  = '0;
        time_in  = '0;
        #13 rst = 1'b1;
        #1;
        chk("rst_outputs", 64'({hash_valid, hash_f_anchor, hash_f_target, hash_dt, hash_t_anchor}), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_dropped", 64'(frames_dropped), 64'(0));
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;

        send_frame(mk(10, 3, 5, 7, 2), 0, 0);
        send_frame(mk(12, 5, 4, 0, 0), 0, 0);
        send_frame(mk(14, 5, 4, 0, 0), 2, 0);
        send_frame(mk(100, 8, 3, 0, 0), 0, 0);
        send_frame(mk(65534, 9, 1, 11, 6), 0, 0);
        send_frame(mk(1, 12, 2, 0, 0), 0, 5);

        // Reset while a hash is being held in the output register.
        @(posedge clk); #1;
        rdy_mode = 3;
        f        = mk(3, 20, 1, 21, 1);
        valid_in = 1'b1;
        ampl_in  = f.ampl;
        freq_in  = f.freq;
        time_in  = f.t;
        @(posedge clk); #1;
        valid_in = 1'b0;
        got_v    = 1'b0;
        for (int i = 0; i < 200 && !got_v; i++) begin
            @(negedge clk);
            got_v = hash_valid;
        end
        chk("wait_reached", 64'(got_v), 64'(1));
        #2 rst = 1'b1;
        #1;
        chk("rst_wait_outputs", 64'({hash_valid, hash_f_anchor, hash_f_target, hash_dt, hash_t_anchor}), 64'(0));
        chk("rst_wait_busy", 64'(busy), 64'(0));
        chk("rst_wait_dropped", 64'(frames_dropped), 64'(0));
        exp_q.delete();
        mdl_hist.delete();
        exp_drops = 0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;

        send_frame(mk(5, 30, 2, 31, 3), 0, 0);

        t_now = 5;
        for (int k = 0; k < 30; k++) begin
            t_now = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 65535))
                                                : (t_now + int'($urandom_range(1, 24))) & 32'hFFFF;
            f.t = TW'(t_now);
            for (int s = 0; s < PEAKS; s++) begin
                f.freq[s] = FW'($urandom_range(0, 511));
                case ($urandom_range(0, 9))
                    0, 1:    f.ampl[s] = '0;
                    2:       f.ampl[s] = AW'($urandom_range(32768, 65535));
                    default: f.ampl[s] = AW'($urandom_range(1, 32767));
                endcase
            end
            send_frame(f, int'($urandom_range(0, 1)),
                       ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 40)) : 0);
        end

        chk("final_dropped", 64'(frames_dropped), 64'(exp_drops));
        chk("final_drain", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
